// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared types and constants for the UART memory sequencer.
// Holds the FSM encoding, opcode values and default reply bytes.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_MEM_WR,
        S_MEM_RD,
        S_RD_WAIT,
        S_TX_START,
        S_TX_WAIT
    } state_t;

    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    function automatic logic is_known_op(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_mem_controller_arbiter.sv
// mem_port_arbiter: fixed-priority share of the single memory port.
// The controller always wins; external reads are pipelined one deep.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_req,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_valid
);

    logic ext_grant;
    logic ctrl_grant;
    logic inflight_q;

    // A new external read is only taken once the previous one has returned.
    assign ctrl_grant = ctrl_req && !rst;
    assign ext_grant  = ext_req && !ctrl_req && !inflight_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= ext_grant;
        end
    end

    always_comb begin
        mem_addr = '0;
        unique case (1'b1)
            ctrl_grant: mem_addr = ctrl_addr;
            ext_grant:  mem_addr = ext_addr;
            default:    mem_addr = '0;
        endcase
    end

    assign ext_valid = inflight_q;
    assign ext_rdata = inflight_q ? mem_rdata : '0;

endmodule

// File: rtl/uart_mem_controller.sv
// uart_mem_controller: parses W/R command frames from the UART and
// drives the pattern memory, sharing its port with the pin-side reader.
module uart_mem_controller
    import uart_mem_pkg::*;
#(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 8,
    parameter int                TIMEOUT_CYCLES = 500000,
    parameter logic [DATA_W-1:0] ACK_BYTE       = DATA_W'(ACK_DEFAULT),
    parameter logic [DATA_W-1:0] NAK_BYTE       = DATA_W'(NAK_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              received,
    input  logic              recv_error,
    output logic [DATA_W-1:0] tx_byte,
    output logic              transmit,
    input  logic              is_transmitting,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_valid,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [7:0]        err_q, err_d;
    logic              in_frame;
    logic              abort;
    logic              ctrl_req;

    assign in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
    // A byte arriving in the same cycle as an error or expiry still counts.
    assign abort = in_frame && !received
                && (recv_error || (tcnt_q == T_LAST));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tx_d     = tx_q;
        tcnt_d   = '0;
        err_d    = err_q;
        transmit = 1'b0;
        mem_we   = 1'b0;
        ctrl_req = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (received) begin
                    op_d = rx_byte;
                    if (is_known_op(8'(rx_byte))) begin
                        state_d = S_GET_ADDR;
                    end else begin
                        tx_d    = NAK_BYTE;
                        state_d = S_TX_START;
                    end
                end
            end
            S_GET_ADDR, S_GET_DATA: begin
                unique case (1'b1)
                    received: begin
                        if (state_q == S_GET_DATA) begin
                            data_d  = rx_byte;
                            state_d = S_MEM_WR;
                        end else begin
                            addr_d  = ADDR_W'(rx_byte);
                            state_d = (op_q == DATA_W'(OP_WRITE))
                                    ? S_GET_DATA : S_MEM_RD;
                        end
                    end
                    abort:   state_d = S_IDLE;
                    default: tcnt_d = tcnt_q + TW'(1);
                endcase
            end
            S_MEM_WR: begin
                ctrl_req = 1'b1;
                mem_we   = 1'b1;
                tx_d     = ACK_BYTE;
                state_d  = S_TX_START;
            end
            S_MEM_RD: begin
                ctrl_req = 1'b1;
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_d    = mem_rdata;
                state_d = S_TX_START;
            end
            S_TX_START: begin
                if (!is_transmitting) begin
                    transmit = 1'b1;
                    state_d  = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (is_transmitting) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tx_q    <= '0;
            tcnt_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    assign tx_byte   = tx_q;
    assign mem_wdata = data_q;
    assign busy      = (state_q != S_IDLE);
    assign err_count = err_q;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .ctrl_req  (ctrl_req),
        .ctrl_addr (addr_q),
        .ext_req   (ext_req),
        .ext_addr  (ext_addr),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .ext_rdata (ext_rdata),
        .ext_valid (ext_valid)
    );

endmodule

// File: tb/tb_uart_mem_controller.sv
// tb_uart_mem_controller: random and directed command traffic against
// a command-level memory model, a UART stub and a pin-side reader.
module tb_uart_mem_controller;

    localparam int         TO   = 100;
    localparam logic [7:0] CW   = 8'h57;
    localparam logic [7:0] CR   = 8'h52;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = '0;
    logic       received = 1'b0;
    logic       recv_error = 1'b0;
    logic [7:0] tx_byte;
    logic       transmit;
    logic       is_transmitting;
    logic       uart_busy = 1'b0;
    logic       uart_hold = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       ext_req = 1'b0;
    logic [7:0] ext_addr = '0;
    logic [7:0] ext_rdata;
    logic       ext_valid;
    logic       busy;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rx = 0;
    int model_err = 0;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] tx_q [$];
    int         tx_cq [$];
    logic [7:0] we_aq [$];
    logic [7:0] we_dq [$];
    int         we_cq [$];
    logic [7:0] ev_dq [$];
    int         ev_cq [$];

    assign is_transmitting = uart_busy | uart_hold;

    uart_mem_controller #(
        .ADDR_W         (8),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_byte         (rx_byte),
        .received        (received),
        .recv_error      (recv_error),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_rdata       (mem_rdata),
        .ext_req         (ext_req),
        .ext_addr        (ext_addr),
        .ext_rdata       (ext_rdata),
        .ext_valid       (ext_valid),
        .busy            (busy),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Pattern memory with registered read; reloaded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
        end else if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= env_mem[mem_addr];
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                we_aq.push_back(mem_addr);
                we_dq.push_back(mem_wdata);
                we_cq.push_back(cyc);
            end
            if (ext_valid) begin
                ev_dq.push_back(ext_rdata);
                ev_cq.push_back(cyc);
            end
        end
    end

    // UART transmitter stub: goes busy the cycle after a transmit pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (transmit) begin
                tx_q.push_back(tx_byte);
                tx_cq.push_back(cyc);
                @(posedge clk);
                #1 uart_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte  = b;
        received = 1'b1;
        last_rx  = cyc;
        @(posedge clk);
        #1 received = 1'b0;
    endtask

    task automatic pulse_err();
        @(posedge clk);
        #1 recv_error = 1'b1;
        @(posedge clk);
        #1 recv_error = 1'b0;
    endtask

    task automatic clear_q();
        tx_q.delete();
        tx_cq.delete();
        we_aq.delete();
        we_dq.delete();
        we_cq.delete();
    endtask

    task automatic bump_err();
        if (model_err < 255) model_err++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 0);
        chk({tag, "_transmit"}, 32'(transmit), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_ext_rdata"}, 32'(ext_rdata), 0);
        chk({tag, "_ext_valid"}, 32'(ext_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
    endtask

    // Send one frame, let it finish, then compare against the model.
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] d);
        logic [7:0] exp_tx;
        int         exp_lat;
        int         exp_we;
        clear_q();
        send_byte(op);
        if (op == CW || op == CR) begin
            gap();
            send_byte(a);
        end
        if (op == CW) begin
            gap();
            send_byte(d);
        end
        repeat (12) @(posedge clk);
        if (op == CW) begin
            ref_mem[a] = d;
            exp_tx  = ACK;
            exp_lat = 2;
            exp_we  = 1;
        end else if (op == CR) begin
            exp_tx  = ref_mem[a];
            exp_lat = 3;
            exp_we  = 0;
        end else begin
            exp_tx  = NAK;
            exp_lat = 1;
            exp_we  = 0;
        end
        chk("tx_count", 32'(tx_q.size()), 1);
        if (tx_q.size() > 0) begin
            chk("tx_byte", 32'(tx_q[0]), 32'(exp_tx));
            chk("latency", 32'(tx_cq[0] - last_rx), 32'(exp_lat));
        end
        chk("we_count", 32'(we_aq.size()), 32'(exp_we));
        if (exp_we == 1 && we_aq.size() > 0) begin
            chk("we_addr", 32'(we_aq[0]), 32'(a));
            chk("we_data", 32'(we_dq[0]), 32'(d));
        end
        @(negedge clk);
        chk("cmd_idle", 32'(busy), 0);
        chk("cmd_err", 32'(err_count), 32'(model_err));
    endtask

    task automatic ext_burst(input int n);
        logic [7:0] ea;
        bit         got;
        for (int k = 0; k < n; k++) begin
            ea       = 8'h80 | 8'($urandom_range(0, 127));
            ext_addr = ea;
            ext_req  = 1'b1;
            got      = 1'b0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (ext_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("ext_seen", 32'(got), 1);
            if (got) chk("ext_rand", 32'(ext_rdata), 32'(ref_mem[ea]));
            @(posedge clk);
            #1 ext_req = 1'b0;
            gap();
        end
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] b;
        int         w;
        int         r;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        do_cmd(CW, 8'h3C, 8'hA5);
        do_cmd(CR, 8'h3C, 8'h00);

        do_cmd(8'h41, 8'h00, 8'h00);
        do_cmd(CR, 8'h00, 8'h00);

        clear_q();
        send_byte(CW);
        send_byte(8'h10);
        repeat (TO / 2) @(posedge clk);
        @(negedge clk);
        chk("to_pending", 32'(busy), 1);
        repeat (TO) @(posedge clk);
        @(negedge clk);
        bump_err();
        chk("to_idle", 32'(busy), 0);
        chk("to_err", 32'(err_count), 32'(model_err));
        chk("to_no_we", 32'(we_aq.size()), 0);
        chk("to_no_tx", 32'(tx_q.size()), 0);

        send_byte(CW);
        pulse_err();
        @(negedge clk);
        bump_err();
        chk("frm_idle", 32'(busy), 0);
        chk("frm_err", 32'(err_count), 32'(model_err));
        pulse_err();
        @(negedge clk);
        chk("idle_err_ignored", 32'(err_count), 32'(model_err));
        do_cmd(CW, 8'h20, 8'h5A);

        // Pin-side reader hammers 0x20 across a write and a read frame.
        ev_dq.delete();
        ev_cq.delete();
        @(posedge clk);
        #1;
        ext_addr = 8'h20;
        ext_req  = 1'b1;
        do_cmd(CW, 8'h20, 8'h77);
        w = (we_cq.size() > 0) ? we_cq[0] : 0;
        do_cmd(CR, 8'h3C, 8'h00);
        @(posedge clk);
        #1 ext_req = 1'b0;
        repeat (3) @(posedge clk);
        chk("ext_pulses", 32'(ev_cq.size() >= 12), 1);
        foreach (ev_cq[i]) begin
            chk("ext_data", 32'(ev_dq[i]),
                (ev_cq[i] - 1 > w) ? 32'h77 : 32'h5A);
            if (i > 0) begin
                chk("ext_gap", 32'((ev_cq[i] - ev_cq[i-1] >= 2)
                    && (ev_cq[i] - ev_cq[i-1] <= 3)), 1);
            end
        end

        // A byte landing while the reply is stalled must be dropped.
        uart_hold = 1'b1;
        clear_q();
        send_byte(CW);
        send_byte(8'h30);
        send_byte(8'h11);
        ref_mem[8'h30] = 8'h11;
        repeat (3) @(posedge clk);
        send_byte(CR);
        repeat (2) @(posedge clk);
        #1 uart_hold = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("drop_tx_count", 32'(tx_q.size()), 1);
        if (tx_q.size() > 0) chk("drop_tx", 32'(tx_q[0]), 32'(ACK));
        chk("drop_idle", 32'(busy), 0);
        chk("drop_err", 32'(err_count), 32'(model_err));
        do_cmd(CR, 8'h30, 8'h00);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            if (b == CW || b == CR) b = 8'h41;
            op = (r < 5) ? CW : (r < 9) ? CR : b;
            fork
                do_cmd(op, 8'($urandom_range(0, 15)), 8'($urandom));
                ext_burst(3);
            join
        end

        for (int n = 0; n < 260; n++) begin
            send_byte(CW);
            pulse_err();
            bump_err();
        end
        @(negedge clk);
        chk("err_saturate", 32'(err_count), 32'(model_err));

        uart_hold = 1'b1;
        clear_q();
        send_byte(CR);
        send_byte(8'h05);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_rst");
        model_err = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        uart_hold = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_tx", 32'(tx_q.size()), 0);
        chk("post_rst_idle", 32'(busy), 0);
        do_cmd(CR, 8'h05, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_controller.md
Name: uart_mem_controller

Overview:
- Command sequencer between the UART byte interface and the 256x8 pattern memory.
- Parses framed commands from received bytes:
  - 'W' (0x57) addr data: write one byte, reply ACK.
  - 'R' (0x52) addr: read one byte, reply with the data byte.
- Owns the single memory port and arbitrates it against an external read requester (the pin-side lookup port).
- Sits between the uart instance and the memory array; replaces the edge-triggered write path with a fully synchronous one.

Parameters:
- ADDR_W, 8, memory address width (depth = 2**ADDR_W).
- DATA_W, 8, memory/UART data width.
- TIMEOUT_CYCLES, 500000, max idle clocks between bytes of one command before abort (10 ms at 50 MHz).
- ACK_BYTE, 8'h06, reply after a successful write.
- NAK_BYTE, 8'h15, reply to an unknown opcode.

Ports:
- clk  input  1  system clock (50 MHz domain)
- rst  input  1  synchronous active-high reset
- rx_byte  input  DATA_W  byte from UART receiver, valid when received=1
- received  input  1  one-cycle strobe, new rx_byte
- recv_error  input  1  one-cycle strobe, UART framing error
- tx_byte  output  DATA_W  byte to UART transmitter
- transmit  output  1  one-cycle strobe, start transmission of tx_byte
- is_transmitting  input  1  UART transmitter busy
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_we  output  1  memory write enable, one cycle
- mem_rdata  input  DATA_W  memory read data, registered, valid 1 cycle after address
- ext_req  input  1  external read request, level, held until ext_valid
- ext_addr  input  ADDR_W  external read address, stable while ext_req=1
- ext_rdata  output  DATA_W  external read data
- ext_valid  output  1  one-cycle strobe, ext_rdata valid
- busy  output  1  high whenever the FSM is not in IDLE
- err_count  output  8  saturating count of aborted commands

Behaviour:
- Reset:
  - State is IDLE.
  - tx_byte, mem_addr, mem_wdata, ext_rdata, err_count and the timeout counter are all 0.
  - transmit, mem_we, ext_valid and busy are all 0.
  - Reset mid-command discards the partial command; no memory write and no reply.
- FSM states and transitions:
  - IDLE: on received, latch the opcode.
    - 'W' or 'R' -> GET_ADDR.
    - Any other opcode -> TX_START with NAK_BYTE.
  - GET_ADDR: on received, latch the address.
    - Opcode 'W' -> GET_DATA.
    - Opcode 'R' -> MEM_RD.
  - GET_DATA: on received, latch the data -> MEM_WR.
  - MEM_WR: mem_we=1 for exactly one cycle with the latched addr/data -> TX_START with ACK_BYTE.
  - MEM_RD: drive mem_addr -> RD_WAIT.
  - RD_WAIT: capture mem_rdata into tx_byte -> TX_START.
  - TX_START: wait until is_transmitting=0, then pulse transmit for one cycle -> TX_WAIT.
  - TX_WAIT: wait for is_transmitting=1 (the UART has accepted the byte) -> IDLE.
- Timeout:
  - The counter resets on every received strobe and on entering GET_ADDR/GET_DATA.
  - It counts only in GET_ADDR and GET_DATA.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, increment err_count, send no reply.
- recv_error:
  - In GET_ADDR or GET_DATA: abort to IDLE and increment err_count.
  - In IDLE: ignored, err_count unchanged.
  - In other states: ignored.
- received outside IDLE/GET_ADDR/GET_DATA: the byte is dropped and not queued; err_count is unchanged.
- err_count saturates at 8'hFF.
- Arbitration:
  - The controller owns the memory port in MEM_WR and MEM_RD; the external port gets it in every other cycle.
  - On a controller conflict the external requester waits; the controller is never stalled.
  - External grant: mem_addr=ext_addr in cycle N; ext_rdata=mem_rdata and ext_valid=1 in cycle N+1.
  - After ext_valid, the next external grant is no earlier than N+2 (ext_req is sampled only when no external read is in flight).
  - A controller access in cycle N+1 does not disturb the in-flight external read. The memory read is registered, so the data for N's address appears at N+1.
- Latency from the last command byte's received strobe to the transmit pulse (UART idle):
  - Write command: 2 cycles.
  - Read command: 3 cycles.
- Read-after-write: a 'R' to the same address returns the newly written data, because the write completes before the read command can be parsed.

Decomposition:
- Shared package uart_mem_pkg holds:
  - The FSM state encoding.
  - Opcode constants OP_WRITE=8'h57 and OP_READ=8'h52.
  - ACK_BYTE/NAK_BYTE defaults.
- One natural sub-module, mem_port_arbiter: fixed-priority two-requester mux with the ext_valid pipeline register.
- The FSM, timeout and err_count remain in uart_mem_controller.

Test Plan:
- Write then read: send 57 3C A5 -> mem_we at addr 0x3C with data 0xA5, tx 0x06. Then send 52 3C -> tx 0xA5.
- Unknown opcode: send 0x41 -> tx 0x15, no mem_we, err_count stays 0. The FSM accepts a following 52 00 normally.
- Timeout: send 57 10 then wait TIMEOUT_CYCLES (set to 100 in the bench) -> back in IDLE, err_count=1, no mem_we, no tx.
- Framing abort: send 57, assert recv_error in GET_ADDR -> IDLE, err_count=1. A subsequent 57 20 5A writes 0x5A at 0x20.
- Arbitration conflict: hold ext_req=1, ext_addr=0x20 continuously while 57 20 77 completes.
  - ext_valid pulses are never lost.
  - Returned data is the old value before the MEM_WR cycle and 0x77 after it.
  - ext_valid never coincides with the controller's own read grant corrupting data.
- Reset mid-operation: assert rst while in TX_START with the UART busy -> all outputs at reset values next cycle, no transmit pulse afterwards.
